// File: rtl/vram_arbiter_pkg.sv
// Shared constants and types for the video RAM scheduler.
//   H_ACTIVE/V_ACTIVE : visible raster size
//   FRAME_WORDS       : framebuffer words fetched per frame
//   PIX_W/VRAM_ADDR_W : pixel width (RGB565) and RAM word address width
//   arb_state_e       : arbiter FSM states
package vram_arbiter_pkg;
    localparam int H_ACTIVE    = 480;
    localparam int V_ACTIVE    = 272;
    localparam int FRAME_WORDS = H_ACTIVE * V_ACTIVE;
    localparam int PIX_W       = 16;
    localparam int VRAM_ADDR_W = 17;
    localparam int PF_DEPTH    = 8;
    localparam int WR_WAIT_MAX = 4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_DONE  = 2'd2
    } arb_state_e;
endpackage

// File: rtl/vram_arbiter_if.sv
// Signal bundle around the VRAM scheduler: timing-generator inputs, pixel
// output, writer handshake and the single-port RAM port.
//   slave  : the arbiter itself
//   master : the surrounding system (timing generator, writer, RAM)
interface vram_arbiter_if
    import vram_arbiter_pkg::*;
#(
    parameter int DATA_W = PIX_W,
    parameter int ADDR_W = VRAM_ADDR_W
) ();
    logic              vsync_i;
    logic              pix_en_i;
    logic [DATA_W-1:0] pix_data_o;
    logic              underflow_o;
    logic              wr_valid_i;
    logic [ADDR_W-1:0] wr_addr_i;
    logic [DATA_W-1:0] wr_data_i;
    logic              wr_ready_o;
    logic [ADDR_W-1:0] mem_addr_o;
    logic              mem_we_o;
    logic [DATA_W-1:0] mem_wdata_o;
    logic [DATA_W-1:0] mem_rdata_i;

    modport slave (
        input  vsync_i, pix_en_i, wr_valid_i, wr_addr_i, wr_data_i, mem_rdata_i,
        output pix_data_o, underflow_o, wr_ready_o, mem_addr_o, mem_we_o, mem_wdata_o
    );

    modport master (
        output vsync_i, pix_en_i, wr_valid_i, wr_addr_i, wr_data_i, mem_rdata_i,
        input  pix_data_o, underflow_o, wr_ready_o, mem_addr_o, mem_we_o, mem_wdata_o
    );
endinterface

// File: rtl/vram_arbiter_sync_fifo.sv
// Pixel prefetch FIFO with a registered head word.
//   clk_i/rstn_i : clock, async active-low reset
//   flush_i      : empty the FIFO (wins over push/pop); head word is kept
//   push_i/push_data_i : write one word
//   pop_i        : drop the head word; ignored when empty
//   head_o       : current head; holds its last value when the FIFO is empty
//   count_o/empty_o : occupancy
module sync_fifo
    import vram_arbiter_pkg::*;
#(
    parameter int DATA_W = PIX_W,
    parameter int DEPTH  = PF_DEPTH
) (
    input  logic                       clk_i,
    input  logic                       rstn_i,
    input  logic                       flush_i,
    input  logic                       push_i,
    input  logic [DATA_W-1:0]          push_data_i,
    input  logic                       pop_i,
    output logic [DATA_W-1:0]          head_o,
    output logic [$clog2(DEPTH):0]     count_o,
    output logic                       empty_o
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0]  count_q;
    logic [DATA_W-1:0] head_q;
    logic              full, empty, push_ok, pop_ok;

    assign full    = (count_q == CNT_W'(DEPTH));
    assign empty   = (count_q == '0);
    assign pop_ok  = pop_i & ~empty;
    assign push_ok = push_i & (~full | pop_ok);

    always_ff @(posedge clk_i) begin
        if (push_ok && !flush_i) begin
            mem[wr_ptr_q] <= push_data_i;
        end
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            head_q   <= '0;
        end else if (flush_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_ok) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            if (pop_ok)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            case ({push_ok, pop_ok})
                2'b10:   count_q <= count_q + CNT_W'(1);
                2'b01:   count_q <= count_q - CNT_W'(1);
                default: ;
            endcase
            // Head tracks mem[rd_ptr]; a word landing in an empty (or
            // just-emptied) FIFO bypasses the array.
            if (pop_ok) begin
                if (count_q == CNT_W'(1)) begin
                    if (push_ok) head_q <= push_data_i;
                end else begin
                    head_q <= mem[rd_ptr_q + PTR_W'(1)];
                end
            end else if (push_ok && empty) begin
                head_q <= push_data_i;
            end
        end
    end

    assign head_o  = head_q;
    assign count_o = count_q;
    assign empty_o = empty;
endmodule

// File: rtl/vram_arbiter.sv
// Single-port VRAM scheduler: keeps the scan-out prefetch FIFO topped up
// from sequential framebuffer addresses and hands every other RAM slot to
// the writer, which is never refused more than WR_MAX_WAIT cycles in a row.
//   clk_i/rstn_i : clock, async active-low reset
//   bus          : vram_arbiter_if.slave (vsync/pixel, writer, RAM port)
//
// state    | meaning
// ST_IDLE  | after reset, no fetches; writer owns every slot
// ST_FETCH | filling the FIFO, writer gets leftover / forced slots
// ST_DONE  | whole frame issued; writer owns every slot
module vram_arbiter
    import vram_arbiter_pkg::*;
#(
    parameter int DATA_W      = PIX_W,
    parameter int ADDR_W      = VRAM_ADDR_W,
    parameter int FB_WORDS    = FRAME_WORDS,
    parameter int FIFO_DEPTH  = PF_DEPTH,
    parameter int WR_MAX_WAIT = WR_WAIT_MAX
) (
    input  logic          clk_i,
    input  logic          rstn_i,
    vram_arbiter_if.slave bus
);
    localparam int CNT_W  = $clog2(FIFO_DEPTH) + 1;
    localparam int OCC_W  = CNT_W + 1;
    localparam int WAIT_W = $clog2(WR_MAX_WAIT + 1);

    arb_state_e        state_q, state_d;
    logic              vsync_q1, vsync_q2, frame_start;
    logic [ADDR_W-1:0] fetch_addr_q, words_left_q;
    logic [WAIT_W-1:0] wait_q;
    logic              rd_valid_q, underflow_q;
    logic              rd_grant, wr_grant, fetch_room, wait_sat;
    logic [CNT_W-1:0]  fifo_count;
    logic [OCC_W-1:0]  occupancy;
    logic              fifo_empty;
    logic [DATA_W-1:0] fifo_head;

    assign frame_start = vsync_q2 & ~vsync_q1;
    // A read in flight already owns a FIFO slot.
    assign occupancy   = {1'b0, fifo_count} + OCC_W'(rd_valid_q);
    assign fetch_room  = occupancy < OCC_W'(FIFO_DEPTH);
    assign wait_sat    = (wait_q == WAIT_W'(WR_MAX_WAIT));

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            vsync_q1 <= 1'b1;
            vsync_q2 <= 1'b1;
        end else begin
            vsync_q1 <= bus.vsync_i;
            vsync_q2 <= vsync_q1;
        end
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) state_q <= ST_IDLE;
        else         state_q <= state_d;
    end

    always_comb begin
        state_d  = state_q;
        rd_grant = 1'b0;
        wr_grant = 1'b0;
        case (state_q)
            ST_IDLE, ST_DONE: wr_grant = bus.wr_valid_i;
            ST_FETCH: begin
                // The frame-start slot is left to the writer; fetching
                // restarts from address 0 on the next cycle.
                if (!frame_start && fetch_room && !wait_sat) rd_grant = 1'b1;
                else                                         wr_grant = bus.wr_valid_i;
            end
            default: ;
        endcase
        if (rd_grant && words_left_q == ADDR_W'(1)) state_d = ST_DONE;
        if (frame_start)                             state_d = ST_FETCH;
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            fetch_addr_q <= '0;
            words_left_q <= '0;
            rd_valid_q   <= 1'b0;
            underflow_q  <= 1'b0;
        end else if (frame_start) begin
            fetch_addr_q <= '0;
            words_left_q <= ADDR_W'(FB_WORDS);
            rd_valid_q   <= 1'b0;
            underflow_q  <= 1'b0;
        end else begin
            rd_valid_q <= rd_grant;
            if (rd_grant) begin
                fetch_addr_q <= fetch_addr_q + ADDR_W'(1);
                words_left_q <= words_left_q - ADDR_W'(1);
            end
            if (bus.pix_en_i && fifo_empty) underflow_q <= 1'b1;
        end
    end

    // A withdrawn request is no longer waiting, so it does not keep
    // blocking display reads.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i)                         wait_q <= '0;
        else if (wr_grant || !bus.wr_valid_i) wait_q <= '0;
        else if (!wait_sat)                  wait_q <= wait_q + WAIT_W'(1);
    end

    sync_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (FIFO_DEPTH)
    ) u_fifo (
        .clk_i       (clk_i),
        .rstn_i      (rstn_i),
        .flush_i     (frame_start),
        .push_i      (rd_valid_q),
        .push_data_i (bus.mem_rdata_i),
        .pop_i       (bus.pix_en_i),
        .head_o      (fifo_head),
        .count_o     (fifo_count),
        .empty_o     (fifo_empty)
    );

    assign bus.pix_data_o  = fifo_head;
    assign bus.underflow_o = underflow_q;
    assign bus.wr_ready_o  = wr_grant;
    assign bus.mem_we_o    = wr_grant;
    assign bus.mem_addr_o  = wr_grant ? bus.wr_addr_i : fetch_addr_q;
    assign bus.mem_wdata_o = bus.wr_data_i;
endmodule

// File: doc/vram_arbiter.md
# vram_arbiter

Single-port video RAM scheduler shared between the display scan-out path and a drawing/CPU writer. Keeps a small pixel prefetch FIFO filled during each frame from sequential framebuffer addresses, and gives the writer all remaining RAM slots, with a bounded-wait guarantee. Sits between the VGA timing generator (vsync, pixel enable) and the framebuffer block RAM.

## Interface
- DATA_W, 16, pixel/word width (RGB565)
- ADDR_W, 17, RAM word address width
- FB_WORDS, 130560, words per frame (480×272), fetched from address 0 upward
- FIFO_DEPTH, 8, prefetch FIFO entries (power of two)
- WR_MAX_WAIT, 4, max consecutive cycles a pending write may be refused

- clk_i  in  1  system clock
- rstn_i  in  1  reset; asynchronous assert, active-low
- vsync_i  in  1  vertical sync from timing generator, active-low pulse
- pix_en_i  in  1  pixel consumed this cycle (active area)
- pix_data_o  out  DATA_W  FIFO head pixel
- underflow_o  out  1  sticky: pix_en_i seen with FIFO empty this frame
- wr_valid_i  in  1  writer request
- wr_addr_i  in  ADDR_W  write address
- wr_data_i  in  DATA_W  write data
- wr_ready_o  out  1  write accepted this cycle (transfer = valid & ready)
- mem_addr_o  out  ADDR_W  RAM address
- mem_we_o  out  1  RAM write enable
- mem_wdata_o  out  DATA_W  RAM write data
- mem_rdata_i  in  DATA_W  RAM read data, 1-cycle latency

## Operation
- States: IDLE (from reset; no fetches, writer gets every cycle), FETCH, DONE (all FB_WORDS issued; writer only).
- Frame start = vsync_i high→low, detected on registered vsync_i. In any state: FIFO flushed, fetch address ← 0, issued-count ← 0, underflow_o ← 0, in-flight read discarded, state ← FETCH.
- Per-cycle grant in FETCH: display read if (fifo_count + inflight) < FIFO_DEPTH and wait counter < WR_MAX_WAIT; else writer if wr_valid_i; else idle (mem_we_o=0).
- Wait counter: increments each cycle wr_valid_i=1 and not granted, saturates at WR_MAX_WAIT, clears on write transfer.
- Display read: mem_addr_o = fetch address, mem_we_o=0; address++; after issuing address FB_WORDS-1 → DONE.
- Write grant: wr_ready_o=1, mem_we_o=1, mem_addr_o/mem_wdata_o = wr_addr_i/wr_data_i. wr_ready_o is combinational from wr_valid_i and grant; never high when wr_valid_i=0.
- pix_en_i pops the FIFO; with FIFO empty: no pop, pix_data_o holds, underflow_o ← 1.
- Simultaneous push and pop: count unchanged. Pop when full while read returns: both occur.
- Frame start coinciding with a write grant: write completes; display reads resume next cycle.

## Timing
- Reset values: pix_data_o=0, underflow_o=0, wr_ready_o=0, mem_we_o=0, mem_addr_o=0, state IDLE, FIFO empty, counters 0.
- Read issued cycle t → mem_rdata_i valid t+1 → written to FIFO at end of t+1 → visible on pix_data_o in t+2 if FIFO was empty.
- Frame start: vsync_i falling at edge e → flush at e+1 (registration delay), first fetch issued cycle after e+1; first pixel available 3 cycles after e+1.
- Worst-case write latency in FETCH: WR_MAX_WAIT+1 cycles from wr_valid_i rising.
- Steady state: 1 pixel/cycle consumption sustained only with writer idle; writer throttles display to ≥ WR_MAX_WAIT/(WR_MAX_WAIT+1) bandwidth.

## Structure
- Shared package vga_pkg: H/V active sizes (480, 272), FB_WORDS, DATA_W, ADDR_W, state enum (IDLE/FETCH/DONE).
- Sub-module sync_fifo (DATA_W × FIFO_DEPTH, push/pop/flush, count, empty/full, registered head output); arbiter FSM, address/issue counters, wait counter in top.

## Test plan
- Reset, no vsync, wr_valid_i=1 for 5 writes addr 0x10..0x14 → wr_ready_o=1 every cycle, mem_we_o=1, pix_data_o=0.
- vsync fall, writer idle → reads addr 0,1,2… back-to-back until count+inflight=8; FIFO full; pix_data_o = RAM[0] 3 cycles after flush.
- FIFO full, pix_en_i continuous, writer idle → one read per cycle, no underflow, pixels RAM[0..N] in order.
- FIFO never full, wr_valid_i held high → writer granted exactly every 5th cycle (WR_MAX_WAIT=4); wait counter clears after each grant.
- pix_en_i asserted with FIFO empty → underflow_o=1, stays set until next vsync fall, then 0.
- vsync fall mid-frame with read in flight → returning word discarded; next pixels from addr 0; after 130560 issues state DONE, no further reads.
